// File: rtl/if_fetch.sv
// Instruction-fetch stage: holds the fetch PC, looks it up in a direct-mapped
// one-word-per-line instruction cache, pushes {instruction, pc} pairs into the
// instruction queue on hits, and refills a line from memory on a miss.
module if_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                IC_LOG2  = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jmp_en_i,
  input  logic [ADDR_W-1:0] jmp_pc_i,
  input  logic              full_i,
  output logic              add_en_o,
  output logic [31:0]       add_data_o,
  output logic [ADDR_W-1:0] add_pc_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_done_i,
  input  logic [31:0]       mem_data_i
);

  localparam int LINES = 1 << IC_LOG2;
  localparam int TAG_W = ADDR_W - IC_LOG2 - 2;

  // IDLE looks the pc up every cycle; MISS waits for the single outstanding refill.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MISS = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] pc;

  logic [LINES-1:0]  line_valid;
  logic [TAG_W-1:0]  line_tag  [LINES];
  logic [31:0]       line_data [LINES];

  logic [IC_LOG2-1:0] rd_idx;
  logic [TAG_W-1:0]   rd_tag;
  logic               hit;
  logic [IC_LOG2-1:0] wr_idx;
  logic [TAG_W-1:0]   wr_tag;
  logic               fill;

  // Lookup of the current pc; purely combinational so a hit can push this cycle.
  assign rd_idx = pc[IC_LOG2+1:2];
  assign rd_tag = pc[ADDR_W-1:IC_LOG2+2];
  assign hit    = line_valid[rd_idx] && (line_tag[rd_idx] == rd_tag);

  // The refill always targets the request address, even if the pc was redirected meanwhile.
  assign wr_idx = mem_addr_o[IC_LOG2+1:2];
  assign wr_tag = mem_addr_o[ADDR_W-1:IC_LOG2+2];
  assign fill   = !rst && rdy && (state == MISS) && mem_done_i;

  // Fetch control: pc, FSM, queue push, memory request and line valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      add_en_o   <= 1'b0;
      add_data_o <= '0;
      add_pc_o   <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      line_valid <= '0;
    end else if (rdy) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values;
      // blocking here would let later statements see this cycle's updates.
      add_en_o <= 1'b0;
      case (state)
        IDLE: begin
          if (jmp_en_i) begin
            pc <= jmp_pc_i;
          end else if (hit) begin
            if (!full_i) begin
              add_en_o   <= 1'b1;
              add_data_o <= line_data[rd_idx];
              add_pc_o   <= pc;
              pc         <= pc + ADDR_W'(4);
            end
          end else begin
            state      <= MISS;
            mem_req_o  <= 1'b1;
            mem_addr_o <= {pc[ADDR_W-1:2], 2'b00};
          end
        end
        MISS: begin
          if (jmp_en_i) begin
            pc <= jmp_pc_i;
          end
          if (mem_done_i) begin
            line_valid[wr_idx] <= 1'b1;
            mem_req_o          <= 1'b0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Cache payload write on refill completion.
  // NOTE: tag and data arrays are deliberately not reset; the valid bits alone
  // decide whether a line is usable, which keeps these arrays plain RAM.
  always_ff @(posedge clk) begin
    if (fill) begin
      line_data[wr_idx] <= mem_data_i;
      line_tag[wr_idx]  <= wr_tag;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a memory responder with programmable latency,
// a monitor logging accepted pushes and issued requests, and a cache/stream model.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        jmp_en_i;
  logic [31:0] jmp_pc_i;
  logic        full_i;
  logic        add_en_o;
  logic [31:0] add_data_o;
  logic [31:0] add_pc_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_done_i;
  logic [31:0] mem_data_i;

  int checks   = 0;
  int failures = 0;
  int mem_lat  = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } push_t;

  push_t       push_q[$];
  logic [31:0] req_q[$];
  logic        rdy_q    = 1'b0;
  logic        req_prev = 1'b0;

  bit          model_valid [256];
  logic [31:0] model_tag   [256];

  if_fetch #(
    .ADDR_W  (32),
    .IC_LOG2 (8),
    .RESET_PC(32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .jmp_en_i   (jmp_en_i),
    .jmp_pc_i   (jmp_pc_i),
    .full_i     (full_i),
    .add_en_o   (add_en_o),
    .add_data_o (add_data_o),
    .add_pc_o   (add_pc_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_done_i (mem_done_i),
    .mem_data_i (mem_data_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Contents of instruction memory; address 0 holds 0x00000013.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  // Whether the edge that produced the current outputs was an active one.
  always @(posedge clk) rdy_q <= rdy && !rst;

  // Log every push the queue would accept and every newly raised request.
  always @(negedge clk) begin
    if (rdy_q && add_en_o) push_q.push_back(push_t'{pc: add_pc_o, data: add_data_o});
    if (rdy_q && mem_req_o && !req_prev) req_q.push_back(mem_addr_o);
    req_prev = mem_req_o;
  end

  // Memory controller: answers a held request after mem_lat cycles with a one-cycle done.
  initial begin
    int cnt;
    cnt        = 0;
    mem_done_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst || mem_done_i || !mem_req_o) begin
        mem_done_i = 1'b0;
        cnt        = 0;
      end else begin
        cnt++;
        if (cnt >= mem_lat) begin
          mem_done_i = 1'b1;
          mem_data_i = mem_word(mem_addr_o);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    push_q.delete();
    req_q.delete();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) begin
      model_valid[i] = 1'b0;
      model_tag[i]   = '0;
    end
  endtask

  // Hold the queue full long enough for any outstanding refill to retire.
  task automatic settle();
    full_i = 1'b1;
    repeat (25) tick();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    jmp_en_i = 1'b0;
    tick();
    tick();
    clear_model();
    clear_logs();
    rst = 1'b0;
  endtask

  // One-cycle redirect strobe; full_i takes full_val on the redirect edge.
  task automatic redirect(input logic [31:0] target, input logic full_val);
    tick();
    jmp_en_i = 1'b1;
    jmp_pc_i = target;
    full_i   = full_val;
    tick();
    jmp_en_i = 1'b0;
  endtask

  // Pushes must be consecutive words from start with memory contents; requests must
  // be exactly the model misses over the fetched pcs plus the pc left pending.
  task automatic check_stream(input logic [31:0] start);
    logic [31:0] exp_req[$];
    logic [31:0] pc;
    int          n;
    int          idx;
    n = push_q.size();
    for (int k = 0; k < n; k++) begin
      pc = start + 32'(k) * 32'd4;
      checks++;
      if (push_q[k].pc !== pc || push_q[k].data !== mem_word(pc)) begin
        failures++;
        $display("FAIL stream_push[%0d]: got pc=%h data=%h expected pc=%h data=%h",
                 k, push_q[k].pc, push_q[k].data, pc, mem_word(pc));
      end
    end
    for (int k = 0; k <= n; k++) begin
      pc  = start + 32'(k) * 32'd4;
      idx = int'((pc >> 2) & 32'hFF);
      if (!(model_valid[idx] && model_tag[idx] == (pc >> 10))) begin
        exp_req.push_back(pc & 32'hFFFF_FFFC);
        model_valid[idx] = 1'b1;
        model_tag[idx]   = pc >> 10;
      end
    end
    checks++;
    if (req_q.size() != exp_req.size()) begin
      failures++;
      $display("FAIL stream_req_count: got %0d expected %0d", req_q.size(), exp_req.size());
    end else begin
      foreach (exp_req[i]) begin
        checks++;
        if (req_q[i] !== exp_req[i]) begin
          failures++;
          $display("FAIL stream_req[%0d]: got %h expected %h", i, req_q[i], exp_req[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rdy      = 1'b0;
    rst      = 1'b1;
    full_i   = 1'b1;
    jmp_en_i = 1'b0;
    jmp_pc_i = '0;
    tick();
    tick();
    checks++;
    if ({add_en_o, add_data_o, add_pc_o, mem_req_o, mem_addr_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got en=%b data=%h pc=%h req=%b addr=%h expected all zero",
               add_en_o, add_data_o, add_pc_o, mem_req_o, mem_addr_o);
    end
    rdy = 1'b1;
    tick();
    checks++;
    if (add_en_o !== 1'b0 || mem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got en=%b req=%b expected 0 0", add_en_o, mem_req_o);
    end
  endtask

  task automatic test_cold_start();
    int          first;
    logic [31:0] seen_pc;
    logic [31:0] seen_data;
    mem_lat = 3;
    full_i  = 1'b0;
    clear_model();
    clear_logs();
    rst = 1'b0;
    tick();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
      failures++;
      $display("FAIL cold_req: got req=%b addr=%h expected 1 00000000", mem_req_o, mem_addr_o);
    end
    first     = 0;
    seen_pc   = 'x;
    seen_data = 'x;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (add_en_o === 1'b1 && first == 0) begin
        first     = k;
        seen_pc   = add_pc_o;
        seen_data = add_data_o;
      end
    end
    checks++;
    if (first != 4) begin
      failures++;
      $display("FAIL cold_latency: got first push %0d cycles after request expected 4", first);
    end
    checks++;
    if (seen_pc !== 32'h0 || seen_data !== 32'h00000013) begin
      failures++;
      $display("FAIL cold_push: got pc=%h data=%h expected 00000000 00000013", seen_pc, seen_data);
    end
    settle();
  endtask

  task automatic test_hit_streaming();
    int found;
    mem_lat = 1 + int'($urandom_range(0, 3));
    full_i  = 1'b0;
    do_reset();
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      tick();
      foreach (push_q[j]) if (push_q[j].pc === 32'hC) found = 1;
    end
    checks++;
    if (found == 0) begin
      failures++;
      $display("FAIL preload_timeout: got no push of pc 0000000c expected one within 200 cycles");
    end
    settle();
    clear_logs();
    redirect(32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (add_en_o !== 1'b1 || add_pc_o !== 32'(k * 4) || add_data_o !== mem_word(32'(k * 4))
          || mem_req_o !== 1'b0) begin
        failures++;
        $display("FAIL hit_stream[%0d]: got en=%b pc=%h data=%h req=%b expected 1 %h %h 0",
                 k, add_en_o, add_pc_o, add_data_o, mem_req_o, 32'(k * 4), mem_word(32'(k * 4)));
      end
    end
  endtask

  task automatic test_backpressure();
    settle();
    clear_logs();
    redirect(32'h0, 1'b0);
    tick();
    tick();
    full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (add_en_o !== 1'b0) begin
        failures++;
        $display("FAIL full_no_push[%0d]: got en=%b pc=%h expected en=0", i, add_en_o, add_pc_o);
      end
    end
    full_i = 1'b0;
    tick();
    checks++;
    if (add_en_o !== 1'b1 || add_pc_o !== 32'h8) begin
      failures++;
      $display("FAIL full_release: got en=%b pc=%h expected 1 00000008", add_en_o, add_pc_o);
    end
    tick();
    full_i = 1'b1;
    repeat (5) tick();
    checks++;
    if (push_q.size() != 4) begin
      failures++;
      $display("FAIL full_push_count: got %0d expected 4", push_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (push_q[k].pc !== 32'(k * 4)) begin
          failures++;
          $display("FAIL full_order[%0d]: got %h expected %h", k, push_q[k].pc, 32'(k * 4));
        end
      end
    end
    settle();
  endtask

  task automatic test_redirect_during_miss();
    int guard;
    mem_lat = 5;
    full_i  = 1'b1;
    do_reset();
    settle();
    redirect(32'h40, 1'b1);
    settle();
    clear_logs();
    redirect(32'h100, 1'b1);
    tick();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin
      failures++;
      $display("FAIL miss_req: got req=%b addr=%h expected 1 00000100", mem_req_o, mem_addr_o);
    end
    jmp_en_i = 1'b1;
    jmp_pc_i = 32'h40;
    full_i   = 1'b0;
    tick();
    jmp_en_i = 1'b0;
    guard    = 0;
    while (mem_req_o === 1'b1 && guard < 20) begin
      checks++;
      if (mem_addr_o !== 32'h100 || add_en_o !== 1'b0) begin
        failures++;
        $display("FAIL miss_hold: got addr=%h en=%b expected 00000100 0", mem_addr_o, add_en_o);
      end
      tick();
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      failures++;
      $display("FAIL miss_timeout: got request still pending after %0d cycles expected done", guard);
    end
    guard = 0;
    while (add_en_o !== 1'b1 && guard < 10) begin
      tick();
      guard++;
    end
    checks++;
    if (add_en_o !== 1'b1 || add_pc_o !== 32'h40 || add_data_o !== mem_word(32'h40)) begin
      failures++;
      $display("FAIL redirect_push: got en=%b pc=%h data=%h expected 1 00000040 %h",
               add_en_o, add_pc_o, add_data_o, mem_word(32'h40));
    end
    settle();
    checks++;
    if (req_q.size() == 0 || req_q[0] !== 32'h100) begin
      failures++;
      $display("FAIL redirect_req_log: got %0d requests first=%h expected first 00000100",
               req_q.size(), (req_q.size() == 0) ? 32'hx : req_q[0]);
    end
    clear_logs();
    redirect(32'h100, 1'b0);
    tick();
    checks++;
    if (add_en_o !== 1'b1 || add_pc_o !== 32'h100 || add_data_o !== mem_word(32'h100)
        || mem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL filled_line_hit: got en=%b pc=%h data=%h req=%b expected 1 00000100 %h 0",
               add_en_o, add_pc_o, add_data_o, mem_req_o, mem_word(32'h100));
    end
    settle();
  endtask

  task automatic test_conflict_eviction();
    mem_lat = 1 + int'($urandom_range(0, 3));
    full_i  = 1'b1;
    do_reset();
    settle();
    redirect(32'h400, 1'b1);
    settle();
    checks++;
    if (req_q.size() != 2 || req_q[1] !== 32'h400) begin
      failures++;
      $display("FAIL alias_fetch: got %0d requests expected 2 ending 00000400", req_q.size());
    end
    clear_logs();
    redirect(32'h0, 1'b1);
    settle();
    checks++;
    if (req_q.size() != 1 || req_q[0] !== 32'h0) begin
      failures++;
      $display("FAIL evicted_refetch: got %0d requests first=%h expected 1 00000000",
               req_q.size(), (req_q.size() == 0) ? 32'hx : req_q[0]);
    end
  endtask

  task automatic test_mid_reset();
    mem_lat = 6;
    full_i  = 1'b1;
    do_reset();
    settle();
    redirect(32'h200, 1'b1);
    tick();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin
      failures++;
      $display("FAIL midrst_miss: got req=%b addr=%h expected 1 00000200", mem_req_o, mem_addr_o);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (mem_req_o !== 1'b0 || add_en_o !== 1'b0) begin
      failures++;
      $display("FAIL midrst_clear: got req=%b en=%b expected 0 0", mem_req_o, add_en_o);
    end
    clear_model();
    clear_logs();
    rst = 1'b0;
    tick();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
      failures++;
      $display("FAIL midrst_restart: got req=%b addr=%h expected 1 00000000", mem_req_o, mem_addr_o);
    end
    settle();
  endtask

  task automatic test_rdy_stall();
    logic [97:0] snap;
    int          guard;
    mem_lat = 2;
    full_i  = 1'b0;
    do_reset();
    guard = 0;
    while (push_q.size() < 2 && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    snap = {add_en_o, add_data_o, add_pc_o, mem_req_o, mem_addr_o};
    rdy  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({add_en_o, add_data_o, add_pc_o, mem_req_o, mem_addr_o} !== snap) begin
        failures++;
        $display("FAIL stall_frozen[%0d]: got %h expected %h", i,
                 {add_en_o, add_data_o, add_pc_o, mem_req_o, mem_addr_o}, snap);
      end
    end
    rdy = 1'b1;
    repeat (30) tick();
    settle();
    check_stream(32'h0);
  endtask

  task automatic test_random();
    logic [31:0] target;
    int          n;
    full_i = 1'b1;
    do_reset();
    settle();
    check_stream(32'h0);
    for (int p = 0; p < 8; p++) begin
      mem_lat = 1 + int'($urandom_range(0, 3));
      if (p == 3) target = 32'hFFFF_FFF0;
      else target = $urandom_range(0, 1) * 32'h400 + $urandom_range(0, 31) * 32'd4;
      clear_logs();
      redirect(target, 1'b1);
      repeat (50) begin
        full_i = ($urandom_range(0, 99) < 30);
        tick();
      end
      settle();
      n = push_q.size();
      checks++;
      if (n < 1) begin
        failures++;
        $display("FAIL random_progress[%0d]: got %0d pushes expected at least 1", p, n);
      end
      check_stream(target);
    end
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_hit_streaming();
    test_backpressure();
    test_redirect_during_miss();
    test_conflict_eviction();
    test_mid_reset();
    test_rdy_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
